// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID pipeline register with valid/ready handshake and a one-deep skid entry.
// Define STAGE_PERF_CNT_EN to add saturating stall/flush counters.
module ifid_skid_stage #(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr
`ifdef STAGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);
   logic               main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
   logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
   logic               accept, deliver;

   assign accept  = in_valid & in_ready_q;
   assign deliver = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_pc_d    = '0;
         main_instr_d = NOP_INSTR;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (deliver) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept && (deliver || !main_valid_q)) begin
         main_valid_d = 1'b1;
         main_pc_d    = in_pc;
         main_instr_d = in_instr;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_pc_d    = in_pc;
         skid_instr_d = in_instr;
      end else if (deliver) begin
         // draining to empty: never leave a stale instruction on the decode side
         main_valid_d = 1'b0;
         main_pc_d    = '0;
         main_instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_pc_q    <= '0;
         main_instr_q <= NOP_INSTR;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         in_ready_q   <= ~skid_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_pc    = main_pc_q;
   assign out_instr = main_instr_q;

`ifdef STAGE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (main_valid_q && !out_ready && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush && (main_valid_q || skid_valid_q) && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end
`endif
endmodule
